// File: rtl/seq_frame_tx_1011_if.sv
// ---------------------------------------------------------------------------
// seq_frame_tx_1011_if
//   Byte handshake plus serial-line bundle for the 1011 frame transmitter.
//
//   tx_data    : payload byte(s), sampled on an accepting edge
//   tx_valid   : payload available
//   tx_ready   : transmitter accepts at the next edge
//   out_bit    : serial line (registered, 0 when idle)
//   tx_busy    : a frame occupies the line this cycle
//   stuff_flag : current out_bit is a stuffed 0
//
//   master : the byte source (drives tx_data/tx_valid, observes the rest)
//   slave  : the transmitter
// ---------------------------------------------------------------------------
interface seq_frame_tx_1011_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              out_bit;
    logic              tx_busy;
    logic              stuff_flag;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  out_bit,
        input  tx_busy,
        input  stuff_flag
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output out_bit,
        output tx_busy,
        output stuff_flag
    );
endinterface

// File: rtl/seq_frame_tx_1011.sv
// ---------------------------------------------------------------------------
// seq_frame_tx_1011
//   Serial frame transmitter feeding the 1011 sequence detector. Each
//   accepted payload goes out as the marker 1011 followed by the payload,
//   MSB first. A 0 is stuffed whenever the last three line bits are 101 and
//   the next bit would be a 1 (except the final marker bit), so 1011 only
//   ever appears on the line as the intended marker.
//
//   Ports:
//     clk    : clock, rising edge
//     reset  : synchronous, active-high
//     tx_if  : slave side of seq_frame_tx_1011_if
//              (tx_data, tx_valid in; tx_ready, out_bit, tx_busy,
//               stuff_flag out)
// ---------------------------------------------------------------------------
module seq_frame_tx_1011 #(
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_frame_tx_1011_if.slave   tx_if
);

    localparam int                CNT_W        = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT     = CNT_W'(DATA_W - 1);
    localparam logic [3:0]        SYNC_PATTERN = 4'b1011;

    // The state names the phase of the *next* bit to be emitted. After the
    // last payload bit leaves, the FSM is back in IDLE, which is exactly the
    // cycle in which a new byte may be accepted without an idle gap.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [1:0]         sync_idx_q, sync_idx_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [DATA_W-1:0]  shift_q,    shift_d;
    logic [2:0]         hist_q;     // last three line bits, [2] oldest
    logic               stuff_q,    stuff_d;
    logic               busy_q,     busy_d;
    logic               out_d;

    state_t             phase;      // phase of the candidate bit this edge
    logic               cand;       // candidate bit before stuffing
    logic               exempt;     // final marker bit is never stuffed
    logic               tx_ready_w;
    logic               accept;

    assign tx_ready_w = (state_q == ST_IDLE) && !reset;
    assign accept     = tx_if.tx_valid && tx_ready_w;

    always_comb begin
        phase      = state_q;
        state_d    = state_q;
        sync_idx_d = sync_idx_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        cand       = 1'b0;
        exempt     = 1'b0;
        out_d      = 1'b0;
        stuff_d    = 1'b0;
        busy_d     = 1'b0;

        // An accept makes the first marker bit the candidate on this edge.
        if (accept) begin
            phase      = ST_SYNC;
            sync_idx_d = 2'd0;
            shift_d    = tx_if.tx_data;
        end

        case (phase)
            ST_SYNC: begin
                cand   = SYNC_PATTERN[2'd3 - sync_idx_d];
                exempt = (sync_idx_d == 2'd3);
            end
            ST_DATA: cand = shift_d[DATA_W-1];
            default: cand = 1'b0;
        endcase

        state_d = phase;
        busy_d  = (phase != ST_IDLE);

        if (phase != ST_IDLE) begin
            if ((hist_q == 3'b101) && cand && !exempt) begin
                // Emit a stuffed 0 and hold position; the same candidate is
                // retried next edge, when hist is 010 and cannot stuff again.
                stuff_d = 1'b1;
            end else begin
                out_d = cand;
                if (phase == ST_SYNC) begin
                    if (sync_idx_d == 2'd3) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else begin
                        sync_idx_d = 2'(sync_idx_d + 2'd1);
                    end
                end else begin
                    shift_d = shift_d << 1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + 1'b1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sync_idx_q <= 2'd0;
            cnt_q      <= '0;
            shift_q    <= '0;
            hist_q     <= 3'b000;
            stuff_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_idx_q <= sync_idx_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            hist_q     <= {hist_q[1:0], out_d};
            stuff_q    <= stuff_d;
            busy_q     <= busy_d;
        end
    end

    // The newest history bit is the registered line value itself.
    assign tx_if.out_bit    = hist_q[0];
    assign tx_if.tx_busy    = busy_q;
    assign tx_if.stuff_flag = stuff_q;
    assign tx_if.tx_ready   = tx_ready_w;

endmodule

// File: tb/tb_seq_frame_tx_1011.sv
`timescale 1ns/1ps
module tb_seq_frame_tx_1011;

    localparam int DATA_W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seq_frame_tx_1011_if #(.DATA_W(DATA_W)) dut_if ();

    seq_frame_tx_1011 #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .tx_if (dut_if)
    );

    // ---------------- bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    endtask

    // ---------------- reference model ----------------
    // Pending frame bits waiting for the line; the stuff rule is applied as
    // bits are taken off the front of the queue.
    typedef struct packed { logic b; logic exempt; } raw_t;
    typedef struct packed { logic b; logic st; logic busy; logic idle; } exp_t;

    raw_t       pending[$];
    exp_t       exp_q[$];
    logic [2:0] m_hist = 3'b000;
    logic [3:0] sync_pat = 4'b1011;
    int         acc_cnt = 0;

    always @(posedge clk) begin : model
        exp_t              e;
        raw_t              r;
        logic [DATA_W-1:0] d;
        if (reset) begin
            pending.delete();
            m_hist = 3'b000;
            e = '{b: 1'b0, st: 1'b0, busy: 1'b0, idle: 1'b1};
        end else begin
            if (dut_if.tx_valid && pending.size() == 0) begin
                d = dut_if.tx_data;
                for (int i = 0; i < 4; i++) begin
                    r.b = sync_pat[3-i]; r.exempt = (i == 3);
                    pending.push_back(r);
                end
                for (int i = DATA_W - 1; i >= 0; i--) begin
                    r.b = d[i]; r.exempt = 1'b0;
                    pending.push_back(r);
                end
                acc_cnt++;
                $display("accept %0d data=0x%02h t=%0t", acc_cnt, d, $time);
            end
            e = '{b: 1'b0, st: 1'b0, busy: 1'b0, idle: 1'b0};
            if (pending.size() != 0) begin
                e.busy = 1'b1;
                if (m_hist == 3'b101 && pending[0].b && !pending[0].exempt) begin
                    e.st = 1'b1;
                end else begin
                    e.b = pending[0].b;
                    void'(pending.pop_front());
                end
            end
            m_hist = {m_hist[1:0], e.b};
            e.idle = (pending.size() == 0);
        end
        exp_q.push_back(e);
    end

    // ---------------- monitor / scoreboard ----------------
    logic [3:0] det = 4'b0000;
    int det_pulses = 0;
    bit rand_phase = 1'b0;
    int busy_cnt = 0;
    int stuff_cnt = 0;

    initial begin : monitor
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL scoreboard: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("out_bit",    64'(dut_if.out_bit),    64'(e.b));
                chk("stuff_flag", 64'(dut_if.stuff_flag), 64'(e.st));
                chk("tx_busy",    64'(dut_if.tx_busy),    64'(e.busy));
                chk("tx_ready",   64'(dut_if.tx_ready),   64'(e.idle && !reset));
            end
            det = {det[2:0], dut_if.out_bit};
            if (det == 4'b1011) det_pulses++;
            if (rand_phase) begin
                if (dut_if.tx_busy)    busy_cnt++;
                if (dut_if.stuff_flag) stuff_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+1; leaves tx_valid high, returns at posedge+1 after the accept.
    task automatic send_byte(input logic [7:0] d);
        int start = acc_cnt;
        bit got = 1'b0;
        dut_if.tx_valid = 1'b1;
        dut_if.tx_data  = d;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge clk); #1;
            if (acc_cnt != start) got = 1'b1;
        end
        if (!got) begin
            n_total++;
            $display("FAIL send_timeout: byte 0x%0h not accepted in 200 cycles", d);
        end
    endtask

    task automatic capture(input int n, output logic [63:0] bits,
                           output logic [63:0] stuffs, output logic [63:0] busys);
        bits = '0; stuffs = '0; busys = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bits   = {bits[62:0],   dut_if.out_bit};
            stuffs = {stuffs[62:0], dut_if.stuff_flag};
            busys  = {busys[62:0],  dut_if.tx_busy};
        end
    endtask

    // ---------------- main sequence ----------------
    logic [63:0] cb, cs, cy;
    int rand_acc0;

    initial begin : stim
        dut_if.tx_valid = 1'b0;
        dut_if.tx_data  = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_out_bit",    64'(dut_if.out_bit),    64'd0);
        chk("reset_tx_busy",    64'(dut_if.tx_busy),    64'd0);
        chk("reset_stuff_flag", 64'(dut_if.stuff_flag), 64'd0);
        chk("reset_tx_ready",   64'(dut_if.tx_ready),   64'd1);

        // 0x00 from idle
        @(posedge clk); #1;
        send_byte(8'h00);
        dut_if.tx_valid = 1'b0;
        capture(13, cb, cs, cy);
        chk("x00_line",  cb, 64'(13'b1011000000000));
        chk("x00_stuff", cs, 64'(13'b0000000000000));
        chk("x00_busy",  cy, 64'(13'b1111111111110));

        // 0xB0: one stuffed bit in the payload
        @(posedge clk); #1;
        send_byte(8'hB0);
        dut_if.tx_valid = 1'b0;
        capture(14, cb, cs, cy);
        chk("xB0_line",  cb, 64'(14'b10111010100000));
        chk("xB0_stuff", cs, 64'(14'b00000001000000));
        chk("xB0_busy",  cy, 64'(14'b11111111111110));

        // back-to-back 0x05 then 0xFF, tx_valid held
        @(posedge clk); #1;
        send_byte(8'h05);
        fork
            begin
                send_byte(8'hFF);
                dut_if.tx_valid = 1'b0;
            end
            capture(26, cb, cs, cy);
        join
        chk("b2b_line",  cb, 64'(26'b10110000010101011111111110));
        chk("b2b_stuff", cs, 64'(26'b00000000000010000000000000));
        chk("b2b_busy",  cy, 64'(26'b11111111111111111111111110));

        // reset during payload bit 3, then a fresh 0x00 frame
        @(posedge clk); #1;
        send_byte(8'h50);
        dut_if.tx_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_bit", 64'(dut_if.out_bit), 64'd0);
        chk("midrst_tx_busy", 64'(dut_if.tx_busy), 64'd0);
        @(posedge clk); #1;
        send_byte(8'h00);
        dut_if.tx_valid = 1'b0;
        capture(13, cb, cs, cy);
        chk("midrst_line",  cb, 64'(13'b1011000000000));
        chk("midrst_stuff", cs, 64'(13'b0000000000000));

        // random regression
        repeat (16) @(posedge clk);
        #1;
        rand_acc0  = acc_cnt;
        rand_phase = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            int gap = $urandom_range(0, 3);
            if (gap != 0) begin
                dut_if.tx_valid = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
            send_byte(8'($urandom_range(0, 255)));
        end
        dut_if.tx_valid = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        rand_phase = 1'b0;
        @(negedge clk);

        chk("detector_pulses", 64'(det_pulses), 64'(acc_cnt));
        chk("frame_length",    64'(busy_cnt),
            64'(12 * (acc_cnt - rand_acc0) + stuff_cnt));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
